// File: rtl/umem_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
//   state_e : arbiter FSM states
//   owner_e : which core port owns the transaction in flight
package umem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/umem_port_arbiter_if.sv
// Bundle of every signal around the unified-memory arbiter.
//   if_*      : instruction-fetch port (core side)
//   dm_*      : load/store data port (core side)
//   mem_*     : single memory port (memory side)
//   proto_err : sticky memory protocol error flag
// Modports:
//   master : the arbiter itself; it masters the memory port and answers the core ports
//   slave  : the surrounding core and memory model
interface umem_port_arbiter_if
  import umem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [BE_W-1:0]   dm_be;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              proto_err;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output proto_err
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  proto_err
  );

endinterface

// File: rtl/umem_prio_sel.sv
// Winner select between fetch and data requests, with a starvation guard.
// Data wins ties until MAX_DBURST data grants have been given back to back while fetch
// was waiting; then fetch wins once.
//   clk, reset : clock, synchronous active-high reset
//   grant_en   : arbiter is in IDLE, so any request present this cycle is granted
//   if_req     : fetch request
//   dm_req     : data request
//   any_req    : at least one request present
//   winner     : port that wins if a grant happens this cycle
module umem_prio_sel
  import umem_pkg::*;
#(
  parameter int unsigned MAX_DBURST = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   grant_en,
  input  logic   if_req,
  input  logic   dm_req,
  output logic   any_req,
  output owner_e winner
);

  localparam int unsigned CNT_W = $clog2(MAX_DBURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DBURST);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starved;

  assign starved = (starve_cnt_q == CNT_MAX);

  always_comb begin
    any_req = if_req | dm_req;
    winner  = (dm_req && !(if_req && starved)) ? OWN_DM : OWN_IF;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_en && any_req) begin
      if (winner == OWN_DM && if_req) begin
        // Fetch lost a contested round; count it, saturating.
        if (!starved) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/umem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch port and the load/store
// data port. One transaction in flight at a time: IDLE grants and latches a request,
// ISSUE holds mem_req until mem_gnt, WAIT_RSP routes the response back one cycle later.
//   clk, reset : clock, synchronous active-high reset
//   bus        : all fetch, data and memory handshake signals plus proto_err
module umem_port_arbiter
  import umem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned MAX_DBURST = 4
) (
  input logic                 clk,
  input logic                 reset,
  umem_port_arbiter_if.master bus
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e state_q, state_d;
  owner_e owner_q, winner;
  logic   any_req, grant, rsp_fire, in_idle;

  logic              mem_req_q, mem_we_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              if_rvalid_q, dm_rvalid_q, proto_err_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  assign in_idle = (state_q == IDLE);

  umem_prio_sel #(
    .MAX_DBURST(MAX_DBURST)
  ) u_prio_sel (
    .clk     (clk),
    .reset   (reset),
    .grant_en(in_idle),
    .if_req  (bus.if_req),
    .dm_req  (bus.dm_req),
    .any_req (any_req),
    .winner  (winner)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (any_req)        state_d = ISSUE;
      ISSUE:    if (bus.mem_gnt)    state_d = WAIT_RSP;
      WAIT_RSP: if (bus.mem_rvalid) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // FSM outputs; grant is masked during reset so no gnt leaks out while being cleared
  always_comb begin
    grant    = 1'b0;
    rsp_fire = 1'b0;
    unique case (state_q)
      IDLE:     grant    = any_req & ~reset;
      WAIT_RSP: rsp_fire = bus.mem_rvalid;
      default:  ;
    endcase
  end

  assign bus.if_gnt = grant & (winner == OWN_IF);
  assign bus.dm_gnt = grant & (winner == OWN_DM);

  // Request latch and response routing
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if_rvalid_q <= rsp_fire & (owner_q == OWN_IF);
      dm_rvalid_q <= rsp_fire & (owner_q == OWN_DM);
      if (rsp_fire) begin
        if (owner_q == OWN_IF) begin
          if_rdata_q <= bus.mem_rdata;
        end else begin
          dm_rdata_q <= mem_we_q ? '0 : bus.mem_rdata;
        end
      end

      if (grant) begin
        owner_q   <= winner;
        mem_req_q <= 1'b1;
        if (winner == OWN_DM) begin
          mem_we_q    <= bus.dm_we;
          mem_be_q    <= bus.dm_be;
          mem_addr_q  <= bus.dm_addr;
          mem_wdata_q <= bus.dm_wdata;
        end else begin
          // Fetch is a full-word read
          mem_we_q    <= 1'b0;
          mem_be_q    <= '1;
          mem_addr_q  <= bus.if_addr;
          mem_wdata_q <= '0;
        end
      end else if (state_q == ISSUE && bus.mem_gnt) begin
        mem_req_q <= 1'b0;
      end

      // A response with no accepted request outstanding is a memory-side protocol bug
      if (bus.mem_rvalid && state_q != WAIT_RSP) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_umem_port_arbiter.sv
// Bench for umem_port_arbiter. A transaction-level model tracks the cycle numbers of each
// grant, memory accept and memory response, and derives every expected output from them.
module tb_umem_port_arbiter;
  import umem_pkg::*;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int          MAX_DBURST = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  umem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  umem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_DBURST(MAX_DBURST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Core side: pending requests are held until granted
  bit                if_pend, dm_pend, if_auto, dm_auto;
  int                p_if, p_dm;
  logic [ADDR_W-1:0] if_a, dm_a;
  logic              dm_w;
  logic [BE_W-1:0]   dm_b;
  logic [DATA_W-1:0] dm_d;

  // Memory side behaviour
  int                dg_max, dr_max, dg_force, dr_force;
  bit                rd_forced, gnt_noise, spur_rv, rst_drv;
  logic [DATA_W-1:0] rd_force;

  // Reference model: timestamps of the open transaction
  int                cyc, t_gnt, t_acc, t_rsp, dg, dr, streak;
  bit                open, m_err;
  owner_e            m_own;
  logic              m_we;
  logic [BE_W-1:0]   m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rsp;

  // Observations
  owner_e            gseq[$];
  int                gcyc[$];
  int                if_rv_cnt, dm_rv_cnt, mreq_cnt, if_rv_cyc;
  logic [ADDR_W-1:0] last_mreq_addr;
  logic [DATA_W-1:0] last_if_rdata, last_dm_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic new_if();
    if_a = $urandom() & 32'hFFFF_FFFC;
  endtask

  task automatic new_dm();
    dm_a = $urandom() & 32'hFFFF_FFFC;
    dm_w = 1'($urandom_range(1));
    dm_b = BE_W'($urandom_range(15));
    dm_d = $urandom();
  endtask

  task automatic model_reset();
    open   = 1'b0;
    t_gnt  = -10;
    t_acc  = -10;
    t_rsp  = -10;
    streak = 0;
    m_err  = 1'b0;
    m_own  = OWN_IF;
    m_we   = 1'b0;
    m_be   = '0;
    m_addr = '0;
    m_wdata = '0;
    m_rsp  = '0;
  endtask

  task automatic clear_obs();
    gseq.delete();
    gcyc.delete();
    if_rv_cnt = 0;
    dm_rv_cnt = 0;
    mreq_cnt  = 0;
    if_rv_cyc = -100;
  endtask

  function automatic logic [1:0] own_at(input int i);
    if (i < gseq.size()) return {1'b0, gseq[i]};
    return 2'b11;
  endfunction

  function automatic int gcyc_at(input int i);
    if (i < gcyc.size()) return gcyc[i];
    return -1000;
  endfunction

  function automatic bit model_idle();
    return !if_pend && !dm_pend && (!open || (t_rsp >= 0 && cyc > t_rsp + 1));
  endfunction

  // One clock cycle: drive at the falling edge, check 1 time unit later, then advance the model
  task automatic cycle();
    bit                awaiting, exp_mreq, free, grant, exp_rv;
    owner_e            win;
    logic              mg, mrv;
    logic [DATA_W-1:0] rdat;
    grant = 1'b0;
    win   = OWN_IF;
    @(negedge clk);
    if (!if_pend && p_if > 0 && int'($urandom_range(99)) < p_if) begin
      if_pend = 1'b1;
      new_if();
    end
    if (!dm_pend && p_dm > 0 && int'($urandom_range(99)) < p_dm) begin
      dm_pend = 1'b1;
      new_dm();
    end
    awaiting = open && (t_acc >= 0) && (t_rsp < 0);
    exp_mreq = open && (t_acc < 0);
    if (exp_mreq) mg = (cyc >= t_gnt + 1 + dg);
    else          mg = gnt_noise && ($urandom_range(3) == 0);
    mrv  = (awaiting && (cyc >= t_acc + 1 + dr)) || spur_rv;
    rdat = rd_forced ? rd_force : DATA_W'($urandom());

    reset          = rst_drv;
    bus.if_req     = if_pend;
    bus.if_addr    = if_a;
    bus.dm_req     = dm_pend;
    bus.dm_we      = dm_w;
    bus.dm_be      = dm_b;
    bus.dm_addr    = dm_a;
    bus.dm_wdata   = dm_d;
    bus.mem_gnt    = mg;
    bus.mem_rvalid = mrv;
    bus.mem_rdata  = rdat;
    #1;

    if (rst_drv) begin
      chk("rst_if_gnt", 64'(bus.if_gnt), 64'(0));
      chk("rst_dm_gnt", 64'(bus.dm_gnt), 64'(0));
    end else begin
      free   = !open || (t_rsp >= 0 && cyc > t_rsp);
      grant  = free && (if_pend || dm_pend);
      win    = (dm_pend && !(if_pend && streak == MAX_DBURST)) ? OWN_DM : OWN_IF;
      exp_rv = open && t_rsp >= 0 && cyc == t_rsp + 1;
      chk("if_gnt", 64'(bus.if_gnt), 64'(grant && win == OWN_IF));
      chk("dm_gnt", 64'(bus.dm_gnt), 64'(grant && win == OWN_DM));
      chk("mem_req", 64'(bus.mem_req), 64'(exp_mreq));
      chk("mem_we", 64'(bus.mem_we), 64'(m_we));
      chk("mem_be", 64'(bus.mem_be), 64'(m_be));
      chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
      chk("if_rvalid", 64'(bus.if_rvalid), 64'(exp_rv && m_own == OWN_IF));
      chk("dm_rvalid", 64'(bus.dm_rvalid), 64'(exp_rv && m_own == OWN_DM));
      if (exp_rv && m_own == OWN_IF) chk("if_rdata", 64'(bus.if_rdata), 64'(m_rsp));
      if (exp_rv && m_own == OWN_DM) chk("dm_rdata", 64'(bus.dm_rdata), 64'(m_rsp));
      chk("proto_err", 64'(bus.proto_err), 64'(m_err));

      if (bus.if_gnt) begin gseq.push_back(OWN_IF); gcyc.push_back(cyc); end
      if (bus.dm_gnt) begin gseq.push_back(OWN_DM); gcyc.push_back(cyc); end
      if (bus.if_rvalid) begin
        if_rv_cnt++;
        if_rv_cyc     = cyc;
        last_if_rdata = bus.if_rdata;
      end
      if (bus.dm_rvalid) begin
        dm_rv_cnt++;
        last_dm_rdata = bus.dm_rdata;
      end
      if (bus.mem_req) begin
        mreq_cnt++;
        last_mreq_addr = bus.mem_addr;
      end
    end

    if (rst_drv) begin
      model_reset();
    end else begin
      if (mrv && !awaiting) m_err = 1'b1;
      if (exp_mreq && mg) t_acc = cyc;
      if (awaiting && mrv) begin
        t_rsp = cyc;
        m_rsp = m_we ? '0 : rdat;
      end
      if (grant) begin
        open  = 1'b1;
        t_gnt = cyc;
        t_acc = -1;
        t_rsp = -1;
        m_own = win;
        dg    = (dg_force >= 0) ? dg_force : int'($urandom_range(dg_max));
        dr    = (dr_force >= 0) ? dr_force : int'($urandom_range(dr_max));
        if (win == OWN_DM) begin
          streak  = if_pend ? ((streak < MAX_DBURST) ? streak + 1 : MAX_DBURST) : 0;
          m_we    = dm_w;
          m_be    = dm_b;
          m_addr  = dm_a;
          m_wdata = dm_d;
          if (dm_auto) new_dm();
          else         dm_pend = 1'b0;
        end else begin
          streak  = 0;
          m_we    = 1'b0;
          m_be    = '1;
          m_addr  = if_a;
          m_wdata = '0;
          if (if_auto) new_if();
          else         if_pend = 1'b0;
        end
      end
    end
    spur_rv = 1'b0;
    cyc++;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (!model_idle() && n < limit) begin
      cycle();
      n++;
    end
    chk("drain_done", 64'(model_idle()), 64'(1));
  endtask

  initial begin
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    if_pend = 0; dm_pend = 0; if_auto = 0; dm_auto = 0; p_if = 0; p_dm = 0;
    if_a = '0; dm_a = '0; dm_w = 1'b0; dm_b = '0; dm_d = '0;
    dg_max = 0; dr_max = 0; dg_force = -1; dr_force = -1;
    rd_forced = 0; rd_force = '0; gnt_noise = 0; spur_rv = 0;
    cyc = 0; dg = 0; dr = 0;
    model_reset();
    clear_obs();

    // Reset, then idle cycles: every output must read 0
    rst_drv = 1'b1;
    repeat (2) cycle();
    rst_drv = 1'b0;
    repeat (2) cycle();

    // 1: lone fetch, immediate memory
    dg_force = 0; dr_force = 0; rd_forced = 1'b1; rd_force = 32'h0050_0093;
    clear_obs();
    if_pend = 1'b1; if_a = 32'h10;
    repeat (6) cycle();
    chk("t1_gnt_count", 64'(gseq.size()), 64'(1));
    chk("t1_gnt_to_rvalid", 64'(if_rv_cyc - gcyc_at(0)), 64'(3));
    chk("t1_if_rdata", 64'(last_if_rdata), 64'(32'h0050_0093));
    chk("t1_mem_addr", 64'(last_mreq_addr), 64'(32'h10));
    chk("t1_mem_req_cycles", 64'(mreq_cnt), 64'(1));
    chk("t1_no_dm_rvalid", 64'(dm_rv_cnt), 64'(0));

    // 2: simultaneous fetch and data write; data goes first
    rd_forced = 1'b0;
    clear_obs();
    if_pend = 1'b1; if_a = 32'h20;
    dm_pend = 1'b1; dm_w = 1'b1; dm_b = 4'hF; dm_a = 32'h200; dm_d = 32'hDEAD_BEEF;
    drain(40);
    chk("t2_first_dm", 64'(own_at(0)), 64'(OWN_DM));
    chk("t2_then_if", 64'(own_at(1)), 64'(OWN_IF));
    chk("t2_dm_rvalid_once", 64'(dm_rv_cnt), 64'(1));
    chk("t2_write_rdata_zero", 64'(last_dm_rdata), 64'(0));

    // 3: both held continuously; fetch gets one slot after every MAX_DBURST data grants
    clear_obs();
    if_pend = 1'b1; new_if(); dm_pend = 1'b1; new_dm();
    if_auto = 1'b1; dm_auto = 1'b1;
    repeat (40) cycle();
    for (int i = 0; i < 10; i++) begin
      chk("t3_order", 64'(own_at(i)), 64'(((i % 5) == 4) ? OWN_IF : OWN_DM));
    end
    if_auto = 1'b0; dm_auto = 1'b0;
    drain(40);

    // 4: slow memory; fetch arriving mid-transaction waits
    dg_force = 3; dr_force = 4;
    clear_obs();
    dm_pend = 1'b1; dm_w = 1'b0; dm_b = 4'h3; dm_a = 32'h300; dm_d = 32'h1234_5678;
    cycle();
    if_pend = 1'b1; if_a = 32'h40;
    drain(60);
    chk("t4_order_dm", 64'(own_at(0)), 64'(OWN_DM));
    chk("t4_order_if", 64'(own_at(1)), 64'(OWN_IF));
    chk("t4_gnt_gap", 64'(gcyc_at(1) - gcyc_at(0)), 64'(10));
    chk("t4_mem_req_cycles", 64'(mreq_cnt), 64'(8));
    chk("t4_one_dm_rvalid", 64'(dm_rv_cnt), 64'(1));
    chk("t4_one_if_rvalid", 64'(if_rv_cnt), 64'(1));

    // Randomized traffic with random memory timing, stray mem_gnt and occasional resets
    dg_force = -1; dr_force = -1; dg_max = 3; dr_max = 3; gnt_noise = 1'b1;
    p_if = 35; p_dm = 45;
    for (int i = 0; i < 3000; i++) begin
      rst_drv = ((i % 1000) == 999);
      cycle();
    end
    rst_drv = 1'b0; p_if = 0; p_dm = 0; gnt_noise = 1'b0;
    drain(100);

    // 5: reset in WAIT_RSP discards the access; a late response flags proto_err
    dg_force = 0; dr_force = 8;
    clear_obs();
    dm_pend = 1'b1; dm_w = 1'b0; dm_b = 4'hF; dm_a = 32'h500; dm_d = '0;
    repeat (3) cycle();
    rst_drv = 1'b1;
    cycle();
    rst_drv = 1'b0;
    repeat (12) cycle();
    chk("t5_no_rvalid", 64'(if_rv_cnt + dm_rv_cnt), 64'(0));
    chk("t5_mem_req_dropped", 64'(bus.mem_req), 64'(0));
    spur_rv = 1'b1;
    cycle();
    repeat (5) cycle();
    chk("t5_proto_err_sticky", 64'(bus.proto_err), 64'(1));
    rst_drv = 1'b1;
    cycle();
    rst_drv = 1'b0;
    cycle();
    chk("t5_proto_err_cleared", 64'(bus.proto_err), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
